easyaxi_ar_arb: RTL

//  - Shares one AXI AR channel between NUM_MST requesting masters (EASYAXI_MST-style AR sources).
//  - Accepts one request at a time from the arbitration winner, registers it, and drives it downstream until the slave accepts.
//  - Prefixes the winner index onto ARID so that the R-channel return can be routed back.
//  - Sits between the master AR ports and the single slave/interconnect AR port.

---
 rtl/easyaxi_ar_arb_pkg.sv | 14 +
 rtl/easyaxi_ar_arb_if.sv | 29 ++
 rtl/easyaxi_rr_arb.sv | 47 ++++
 rtl/easyaxi_ar_arb.sv | 74 +++++++
 4 files changed

// File: rtl/easyaxi_ar_arb_pkg.sv
// Shared widths and payload type for the AR-channel arbiter slice.
// These values mirror the easy_axi defines so the arbiter builds without the Verilog include.
package easyaxi_ar_arb_pkg;

    localparam int AXI_ID_WIDTH    = 4;
    localparam int AXI_ADDR_WIDTH  = 32;
    localparam int AXI_ARB_NUM_MST = 4;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
    } ar_payload_t;

endpackage

// File: rtl/easyaxi_ar_arb_if.sv
// AR bundle between NUM_MST upstream requesters and the single downstream AR port.
// The slave modport is the arbiter's view; the master modport drives it.
interface easyaxi_ar_arb_if
    import easyaxi_ar_arb_pkg::*;
#(
    parameter int NUM_MST = AXI_ARB_NUM_MST
);
    localparam int IDX_W = $clog2(NUM_MST);

    logic [NUM_MST-1:0]                s_arvalid;
    logic [NUM_MST-1:0]                s_arready;
    logic [NUM_MST*AXI_ID_WIDTH-1:0]   s_arid;
    logic [NUM_MST*AXI_ADDR_WIDTH-1:0] s_araddr;
    logic                              m_arvalid;
    logic                              m_arready;
    logic [IDX_W+AXI_ID_WIDTH-1:0]     m_arid;
    logic [AXI_ADDR_WIDTH-1:0]         m_araddr;

    modport slave (
        input  s_arvalid, s_arid, s_araddr, m_arready,
        output s_arready, m_arvalid, m_arid, m_araddr
    );

    modport master (
        output s_arvalid, s_arid, s_araddr, m_arready,
        input  s_arready, m_arvalid, m_arid, m_araddr
    );

endinterface

// File: rtl/easyaxi_rr_arb.sv
// Combinational arbiter: round-robin starting after ptr, or lowest index first
// when EASYAXI_AR_ARB_FIXPRI_EN is defined (ptr is then ignored).
module easyaxi_rr_arb #(
    parameter  int NUM_MST = 4,
    localparam int IDX_W   = $clog2(NUM_MST)
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_MST-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

`ifdef EASYAXI_AR_ARB_FIXPRI_EN
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            if (req[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = ptr;
        // Explicit wrap keeps cand below NUM_MST even when NUM_MST is not a power of two.
        for (int k = 0; k < NUM_MST; k++) begin
            cand = (cand == IDX_W'(NUM_MST - 1)) ? '0 : cand + 1'b1;
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end
`endif

    assign gnt = gnt_vld ? (NUM_MST'(1) << gnt_idx) : '0;

endmodule

// File: rtl/easyaxi_ar_arb.sv
// AR arbiter: one registered downstream slot fed by the arbitration winner, winner index prefixed on ARID.
// Define EASYAXI_AR_ARB_FIXPRI_EN for fixed priority (no rr_ptr); default is round-robin.
module easyaxi_ar_arb
    import easyaxi_ar_arb_pkg::*;
#(
    parameter  int NUM_MST = AXI_ARB_NUM_MST,
    localparam int IDX_W   = $clog2(NUM_MST)
) (
    input  logic           clk,
    input  logic           rst,
    easyaxi_ar_arb_if.slave bus
);

    logic [NUM_MST-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   arb_ptr;
    logic               gnt_vld;
    logic               slot_free;
    logic               up_hs;
    ar_payload_t        sel;

`ifdef EASYAXI_AR_ARB_FIXPRI_EN
    assign arb_ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr;

    // Reset value NUM_MST-1 makes requester 0 the first winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rr_ptr <= IDX_W'(NUM_MST - 1);
        else if (up_hs) rr_ptr <= gnt_idx;
    end

    assign arb_ptr = rr_ptr;
`endif

    easyaxi_rr_arb #(.NUM_MST(NUM_MST)) u_arb (
        .req     (bus.s_arvalid),
        .ptr     (arb_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // The slot can take a new request when empty or when it is emptying this cycle.
    assign slot_free     = ~bus.m_arvalid | bus.m_arready;
    assign up_hs         = slot_free & gnt_vld;
    assign bus.s_arready = slot_free ? gnt : '0;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel.id   = bus.s_arid[i*AXI_ID_WIDTH +: AXI_ID_WIDTH];
                sel.addr = bus.s_araddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
        if (rst) begin
            bus.m_arvalid <= 1'b0;
            bus.m_arid    <= '0;
            bus.m_araddr  <= '0;
        end else if (up_hs) begin
            bus.m_arvalid <= 1'b1;
            bus.m_arid    <= {gnt_idx, sel.id};
            bus.m_araddr  <= sel.addr;
        end else if (bus.m_arready) begin
            bus.m_arvalid <= 1'b0;
        end
    end

endmodule
